serial_rx_deserializer: RTL and testbench
=========================================

Name: serial_rx_deserializer

Overview:
- Receiving end of the controller's serial data link. It samples the bit stream shifted out while the transmit strobe is high and reassembles DATA_WIDTH-bit words, MSB first.
- Finished words are presented on a valid/ready output buffer to the host-side consumer.
- Detects truncated frames and overruns, and reports BUSY the same way the controller does.

Parameters:
- DATA_WIDTH, 8, word length in bits; legal range 2..32.
- CNT_WIDTH, 5, bit-counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH (+1 with parity).

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- SERIAL_DATA  input  1  serial data bit, valid while SERIAL_EN=1.
- SERIAL_EN  input  1  transmit strobe; high for exactly one frame's bit-times, one bit per clock.
- DATA_OUT  output  DATA_WIDTH  received word; stable while DATA_VALID=1.
- DATA_VALID  output  1  output buffer holds an unconsumed word.
- DATA_READY  input  1  consumer accepts DATA_OUT when DATA_VALID & DATA_READY.
- BUSY  output  1  high while a frame is being shifted in.
- FRAME_ERR  output  1  one-cycle pulse when a frame is truncated.
- OVERRUN  output  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset (async, any state, mid-frame included):
  - state=IDLE; shift register, bit counter and DATA_OUT = 0.
  - DATA_VALID, BUSY, FRAME_ERR, OVERRUN = 0.
  - Any partial frame is lost.
- States: IDLE, SHIFT.
- IDLE:
  - SERIAL_EN=1: shift_reg <= {shift_reg[DATA_WIDTH-2:0], SERIAL_DATA}, cnt <= 1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, SERIAL_EN=1 and cnt<FRAME_LEN: shift the bit in, cnt++.
  - FRAME_LEN = DATA_WIDTH, or DATA_WIDTH+1 with parity.
- Frame completion: the cycle in which the last bit is sampled (cnt reaches FRAME_LEN on that edge).
  - Word goes to the output buffer on that edge (see buffer rules).
  - Next state = IDLE; cnt cleared.
  - Latency: DATA_VALID rises on the same edge that samples the last bit.
- Back-to-back frames: if SERIAL_EN stays high after completion, the next bit is sampled from IDLE as bit 0 of a new frame. No gap is required.
- Truncation: in SHIFT with SERIAL_EN=0 and cnt<FRAME_LEN:
  - FRAME_ERR pulses for 1 cycle; partial word discarded; go to IDLE.
  - The output buffer is untouched.
- BUSY is registered: 1 while state=SHIFT, 0 in IDLE.
- Output buffer (single entry):
  - Consume: DATA_VALID & DATA_READY at an edge clears DATA_VALID, unless a word completes on the same edge.
  - Complete while empty, or while full and consumed on the same edge: load DATA_OUT, DATA_VALID=1, no overrun.
  - Complete while full and not consumed: new word dropped, DATA_OUT unchanged, OVERRUN pulses 1 cycle.
  - DATA_READY with DATA_VALID=0 has no effect.
- FRAME_ERR and OVERRUN never pulse on the same edge.
- Bit order: the first bit received lands in DATA_OUT[DATA_WIDTH-1].

Optional Feature:
- Macro: SERIAL_RX_PARITY_CHECK_EN.
- Defined:
  - Adds output PARITY_ERR (1 bit); reset value 0.
  - FRAME_LEN = DATA_WIDTH+1; the final bit is an even-parity bit over the data bits.
  - On a mismatch at completion: word dropped (buffer untouched), PARITY_ERR pulses 1 cycle, no OVERRUN that cycle.
- Undefined: no PARITY_ERR port; FRAME_LEN = DATA_WIDTH.

Decomposition:
- Shared package serial_link_pkg:
  - state encoding constants RX_IDLE=1'b0, RX_SHIFT=1'b1;
  - default DATA_WIDTH constant LINK_DATA_WIDTH=8, also used by the transmit-side serializer.
- Sub-module serial_rx_shifter: shift register plus bit counter.
  - Inputs: shift enable, clear, bit.
  - Outputs: word, cnt, frame_full.
- Top level holds the FSM, output buffer and error pulses.

Test Plan:
- Single frame: after reset, SERIAL_EN=1 for 8 cycles with bits 1,0,1,0,0,1,0,1 -> DATA_OUT=8'hA5 and DATA_VALID=1 on the 8th edge. BUSY=1 for cycles 1-7. DATA_READY=1 one cycle later -> DATA_VALID=0.
- Back-to-back frames: frames 8'h3C then 8'hC3 with no gap, DATA_READY held 1 -> two valid words, each valid for exactly 1 cycle. FRAME_ERR and OVERRUN stay 0.
- Overrun: 8'h11 received with DATA_READY=0, then 8'h22 completes -> OVERRUN pulses 1 cycle and DATA_OUT stays 8'h11. With DATA_READY=1 on the completion edge instead -> DATA_OUT=8'h22 and no OVERRUN.
- Truncated frame: SERIAL_EN high for 5 cycles, then low -> FRAME_ERR pulses 1 cycle after the drop, DATA_VALID unchanged. A following full 8'hFF frame is received correctly.
- Reset mid-frame: assert RESET asynchronously after 4 bits -> all outputs 0 immediately. After release, a fresh 8'h5A frame is received correctly.
- Parity (macro defined): frame 8'h07 with parity bit 1 -> accepted. Same frame with parity bit 0 -> PARITY_ERR pulses 1 cycle and DATA_VALID stays 0.

Source files
------------

// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared receive-FSM encoding and default word width for the serial link.
package serial_link_pkg;
  typedef enum logic {RX_IDLE = 1'b0, RX_SHIFT = 1'b1} rx_state_t;
  localparam int LINK_DATA_WIDTH = 8;
endpackage

// File: rtl/serial_rx_shifter.sv
// serial_rx_shifter: frame shift register and bit counter; o_frame already includes the bit being sampled.
module serial_rx_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 5,
  parameter int FRAME_LEN  = DATA_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_shift,
  input  logic                 i_clear,
  input  logic                 i_bit,
  output logic [FRAME_LEN-1:0] o_frame,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_frame_full
);
  logic [FRAME_LEN-1:0] r_sr;
  logic [CNT_WIDTH-1:0] r_cnt;
  assign o_frame      = {r_sr[FRAME_LEN-2:0], i_bit};
  assign o_cnt        = r_cnt;
  assign o_frame_full = r_cnt == CNT_WIDTH'(FRAME_LEN - 1);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      r_sr  <= i_shift ? o_frame : (i_clear ? '0 : r_sr);
      r_cnt <= i_clear ? '0 : (i_shift ? r_cnt + CNT_WIDTH'(1) : r_cnt);
    end
  end
endmodule

// File: rtl/serial_rx_deserializer.sv
// serial_rx_deserializer: MSB-first serial receiver with single-entry valid/ready buffer and error pulses.
// Optional even-parity bit per frame when SERIAL_RX_PARITY_CHECK_EN is defined.
module serial_rx_deserializer
  import serial_link_pkg::*;
#(
  parameter int DATA_WIDTH = LINK_DATA_WIDTH,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_serial_data,
  input  logic                  i_serial_en,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic                  o_busy,
  output logic                  o_frame_err,
  output logic                  o_overrun
`ifdef SERIAL_RX_PARITY_CHECK_EN
  ,
  output logic                  o_parity_err
`endif
);
`ifdef SERIAL_RX_PARITY_CHECK_EN
  localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
  localparam int FRAME_LEN = DATA_WIDTH;
`endif
  rx_state_t             r_state, w_next_state;
  logic [FRAME_LEN-1:0]  w_frame;
  logic [CNT_WIDTH-1:0]  w_cnt;
  logic                  w_frame_full, w_complete, w_trunc, w_clear, w_par_ok, w_load, w_drop;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid, r_frame_err, r_overrun;

  serial_rx_shifter #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH), .FRAME_LEN(FRAME_LEN)) u_shifter (
    .i_clk       (i_clk),
    .i_rst       (i_reset),
    .i_shift     (i_serial_en),
    .i_clear     (w_clear),
    .i_bit       (i_serial_data),
    .o_frame     (w_frame),
    .o_cnt       (w_cnt),
    .o_frame_full(w_frame_full)
  );

`ifdef SERIAL_RX_PARITY_CHECK_EN
  logic r_parity_err;
  assign w_par_ok     = ~^w_frame;
  assign o_parity_err = r_parity_err;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_parity_err <= 1'b0;
    else r_parity_err <= w_complete & ~w_par_ok;
  end
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= RX_IDLE;
    else r_state <= w_next_state;
  end

  // A nonzero bit count means a frame is in flight, so a dropped strobe truncates it.
  always_comb begin
    w_complete   = i_serial_en & w_frame_full;
    w_trunc      = ~i_serial_en & (w_cnt != '0);
    w_clear      = w_complete | w_trunc;
    w_next_state = (i_serial_en & ~w_frame_full) ? RX_SHIFT : RX_IDLE;
    w_load       = w_complete & w_par_ok & (~r_valid | i_data_ready);
    w_drop       = w_complete & w_par_ok & r_valid & ~i_data_ready;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_valid     <= w_load | (r_valid & ~i_data_ready);
      r_data      <= w_load ? w_frame[FRAME_LEN-1 -: DATA_WIDTH] : r_data;
      r_frame_err <= w_trunc;
      r_overrun   <= w_drop;
    end
  end

  assign o_data_out   = r_data;
  assign o_data_valid = r_valid;
  assign o_busy       = r_state == RX_SHIFT;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;
endmodule

// File: tb/tb_serial_rx_deserializer.sv
// tb_serial_rx_deserializer: directed plus random stimulus checked every cycle against a frame-level model.
module tb_serial_rx_deserializer;
  localparam int DW = 8;
`ifdef SERIAL_RX_PARITY_CHECK_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif
  logic clk = 1'b0, rst = 1'b1, sdata = 1'b0, sen = 1'b0, rdy = 1'b0;
  logic [DW-1:0] dout;
  logic valid, busy, ferr, ovr, perr;
  int n_chk = 0, n_fail = 0;

  serial_rx_deserializer dut (
    .i_clk(clk), .i_reset(rst), .i_serial_data(sdata), .i_serial_en(sen),
    .o_data_out(dout), .o_data_valid(valid), .i_data_ready(rdy),
    .o_busy(busy), .o_frame_err(ferr), .o_overrun(ovr)
`ifdef SERIAL_RX_PARITY_CHECK_EN
    , .o_parity_err(perr)
`endif
  );
`ifndef SERIAL_RX_PARITY_CHECK_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  // Frame-level model: bits collected per frame, buffer as a single slot.
  int m_n;
  logic [63:0] m_acc;
  logic [DW-1:0] m_data;
  logic m_valid, m_fe, m_ov, m_pe;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_acc = 0; m_data = 0; m_valid = 0; m_fe = 0; m_ov = 0; m_pe = 0;
    end else begin
      logic done, cons;
      done = 0; m_fe = 0; m_ov = 0; m_pe = 0;
      cons = m_valid && rdy;
      if (sen) begin
        m_acc = ((m_acc << 1) | 64'(sdata)) & ((64'd1 << FL) - 1);
        m_n++;
        if (m_n == FL) begin done = 1; m_n = 0; end
      end else begin
        if (m_n > 0) m_fe = 1;
        m_n = 0;
      end
      if (cons) m_valid = 0;
      if (done) begin
        if (FL != DW && ($countones(m_acc) % 2) != 0) m_pe = 1;
        else if (m_valid) m_ov = 1;
        else begin m_valid = 1; m_data = DW'(m_acc >> (FL - DW)); end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("data_out", 32'(dout), 32'(m_data));
    chk("data_valid", 32'(valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_n > 0));
    chk("frame_err", 32'(ferr), 32'(m_fe));
    chk("overrun", 32'(ovr), 32'(m_ov));
    chk("parity_err", 32'(perr), 32'(m_pe));
  end

  task automatic drive(input logic e, input logic b, input logic r);
    sen = e; sdata = b; rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input logic r_body, input logic r_last);
    for (int i = DW - 1; i >= 0; i--)
      drive(1'b1, w[i], (FL == DW && i == 0) ? r_last : r_body);
`ifdef SERIAL_RX_PARITY_CHECK_EN
    drive(1'b1, ^w, r_last);
`endif
  endtask

  initial begin
    logic [DW-1:0] w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    w = 8'hA5;
    for (int i = DW - 1; i >= 0; i--) begin
      drive(1'b1, w[i], 1'b0);
      if (i == DW - 1) chk("a5_busy_first", 32'(busy), 1);
    end
`ifdef SERIAL_RX_PARITY_CHECK_EN
    drive(1'b1, ^w, 1'b0);
`endif
    chk("a5_data", 32'(dout), 32'h A5);
    chk("a5_valid", 32'(valid), 1);
    chk("a5_busy_done", 32'(busy), 0);
    drive(1'b0, 1'b0, 1'b1);
    chk("a5_consumed", 32'(valid), 0);
    send_frame(8'h3C, 1'b1, 1'b1);
    chk("b2b_first", 32'(dout), 32'h3C);
    send_frame(8'hC3, 1'b1, 1'b1);
    chk("b2b_second", 32'(dout), 32'hC3);
    chk("b2b_valid", 32'(valid), 1);
    drive(1'b0, 1'b0, 1'b1);
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    chk("ovr_pulse", 32'(ovr), 1);
    chk("ovr_keep", 32'(dout), 32'h11);
    drive(1'b0, 1'b0, 1'b0);
    chk("ovr_one_cycle", 32'(ovr), 0);
    send_frame(8'h22, 1'b0, 1'b1);
    chk("swap_data", 32'(dout), 32'h22);
    chk("swap_no_ovr", 32'(ovr), 0);
    repeat (5) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("trunc_ferr", 32'(ferr), 1);
    chk("trunc_valid", 32'(valid), 1);
    chk("trunc_data", 32'(dout), 32'h22);
    drive(1'b0, 1'b0, 1'b0);
    chk("trunc_one_cycle", 32'(ferr), 0);
    send_frame(8'hFF, 1'b1, 1'b1);
    chk("ff_data", 32'(dout), 32'hFF);
    repeat (4) drive(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(dout), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    sen = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0);
    chk("5a_data", 32'(dout), 32'h5A);
`ifdef SERIAL_RX_PARITY_CHECK_EN
    drive(1'b0, 1'b0, 1'b1);
    w = 8'h07;
    for (int i = DW - 1; i >= 0; i--) drive(1'b1, w[i], 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("par_ok_data", 32'(dout), 32'h07);
    chk("par_ok_valid", 32'(valid), 1);
    drive(1'b0, 1'b0, 1'b1);
    for (int i = DW - 1; i >= 0; i--) drive(1'b1, w[i], 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("par_bad_pulse", 32'(perr), 1);
    chk("par_bad_valid", 32'(valid), 0);
`endif
    for (int c = 0; c < 800; c++)
      drive($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom));
    drive(1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
